// File: rtl/irrigation_pkg.sv
// Shared irrigation types and default dimensions used by the zone sequencer and the irrigation top.
package irrigation_pkg;

  localparam int NUM_ZONES    = 4;
  localparam int ZONE_W       = 2;
  localparam int DUR_W        = 8;
  localparam int SETTLE_TICKS = 2;
  localparam int DEFAULT_DUR  = 10;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    RUN,
    PAUSE,
    SETTLE,
    DONE
  } seq_state_t;

endpackage

// File: rtl/zone_sequencer_if.sv
// Control/status bundle between the irrigation controller (master) and the zone sequencer (slave).
interface zone_sequencer_if #(
  parameter int NUM_ZONES = irrigation_pkg::NUM_ZONES,
  parameter int ZONE_W    = irrigation_pkg::ZONE_W,
  parameter int DUR_W     = irrigation_pkg::DUR_W
);
  logic                 tick;
  logic                 start;
  logic                 abort;
  logic                 rain;
  logic [NUM_ZONES-1:0] zone_enable;
  logic [NUM_ZONES-1:0] quota_exceeded;
  logic                 dur_wr;
  logic [ZONE_W-1:0]    dur_zone;
  logic [DUR_W-1:0]     dur_val;

  logic [ZONE_W-1:0]    zone;
  logic                 valve_req;
  logic                 busy;
  logic                 paused;
  logic                 done;
  logic [DUR_W-1:0]     remaining;

  modport master (
    output tick, start, abort, rain, zone_enable, quota_exceeded,
           dur_wr, dur_zone, dur_val,
    input  zone, valve_req, busy, paused, done, remaining
  );

  modport slave (
    input  tick, start, abort, rain, zone_enable, quota_exceeded,
           dur_wr, dur_zone, dur_val,
    output zone, valve_req, busy, paused, done, remaining
  );
endinterface

// File: rtl/zone_dur_regs.sv
// Per-zone watering duration table: one write port, combinational read by zone index.
module zone_dur_regs #(
  parameter int NUM_ZONES   = irrigation_pkg::NUM_ZONES,
  parameter int ZONE_W      = irrigation_pkg::ZONE_W,
  parameter int DUR_W       = irrigation_pkg::DUR_W,
  parameter int DEFAULT_DUR = irrigation_pkg::DEFAULT_DUR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ZONE_W-1:0] wr_zone,
  input  logic [DUR_W-1:0]  wr_val,
  input  logic [ZONE_W-1:0] rd_idx,
  output logic [DUR_W-1:0]  rd_val
);

  logic [DUR_W-1:0] dur_q [NUM_ZONES];

  // NOTE: this table is small and must come up with usable durations, so every
  // entry is reset; large RAM-style memories are normally left unreset.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ZONES; i++) begin
        dur_q[i] <= DUR_W'(DEFAULT_DUR);
      end
    end else if (wr_en && (int'(wr_zone) < NUM_ZONES)) begin
      dur_q[wr_zone] <= wr_val;
    end
  end

  // Reads see the pre-write value in the write cycle, so a same-clk load gets the old duration.
  assign rd_val = dur_q[rd_idx];

endmodule

// File: rtl/zone_sequencer.sv
// Auto-cycle scheduler: walks the zones in order, opening each eligible valve for its programmed ticks.
module zone_sequencer #(
  parameter int NUM_ZONES    = irrigation_pkg::NUM_ZONES,
  parameter int ZONE_W       = irrigation_pkg::ZONE_W,
  parameter int DUR_W        = irrigation_pkg::DUR_W,
  parameter int SETTLE_TICKS = irrigation_pkg::SETTLE_TICKS,
  parameter int DEFAULT_DUR  = irrigation_pkg::DEFAULT_DUR
) (
  input  logic           clk,
  input  logic           rst_n,
  zone_sequencer_if.slave bus
);
  import irrigation_pkg::*;

  localparam logic [ZONE_W-1:0] LAST_IDX = ZONE_W'(NUM_ZONES - 1);
  localparam logic [DUR_W-1:0]  GAP_LOAD = DUR_W'(SETTLE_TICKS);

  seq_state_t        state_q, state_d;
  logic [ZONE_W-1:0] idx_q, idx_d;
  logic [DUR_W-1:0]  rem_q, rem_d;
  logic [DUR_W-1:0]  gap_q, gap_d;
  logic [DUR_W-1:0]  dur_rd;
  logic              eligible;

  zone_dur_regs #(
    .NUM_ZONES  (NUM_ZONES),
    .ZONE_W     (ZONE_W),
    .DUR_W      (DUR_W),
    .DEFAULT_DUR(DEFAULT_DUR)
  ) u_dur_regs (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (bus.dur_wr),
    .wr_zone(bus.dur_zone),
    .wr_val (bus.dur_val),
    .rd_idx (idx_q),
    .rd_val (dur_rd)
  );

  assign eligible = bus.zone_enable[idx_q] & ~bus.quota_exceeded[idx_q] & (dur_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    gap_d   = gap_q;

    unique case (state_q)
      IDLE: begin
        idx_d = '0;
        if (bus.start) state_d = SELECT;
      end
      SELECT: begin
        if (eligible) begin
          rem_d   = dur_rd;
          state_d = RUN;
        end else if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + ZONE_W'(1);
        end
      end
      RUN: begin
        if (bus.rain) begin
          state_d = PAUSE;
        end else if (bus.quota_exceeded[idx_q]) begin
          gap_d   = GAP_LOAD;
          state_d = SETTLE;
        end else if (bus.tick) begin
          if (rem_q <= DUR_W'(1)) begin
            rem_d   = '0;
            gap_d   = GAP_LOAD;
            state_d = SETTLE;
          end else begin
            rem_d = rem_q - DUR_W'(1);
          end
        end
      end
      PAUSE: begin
        if (!bus.rain) state_d = RUN;
      end
      SETTLE: begin
        if (gap_q == '0) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ZONE_W'(1);
            state_d = SELECT;
          end
        end else if (bus.tick) begin
          gap_d = gap_q - DUR_W'(1);
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort outranks everything, including a coincident start.
    if (bus.abort) begin
      state_d = IDLE;
      idx_d   = '0;
      rem_d   = '0;
      gap_d   = '0;
    end
  end

  assign bus.zone      = idx_q;
  assign bus.valve_req = (state_q == RUN);
  assign bus.busy      = (state_q != IDLE);
  assign bus.paused    = (state_q == PAUSE);
  assign bus.done      = (state_q == DONE);
  assign bus.remaining = rem_q;

endmodule

// File: doc/zone_sequencer.md
# zone_sequencer

Auto-cycle scheduler for the smart irrigation system. On a start pulse it walks the watering zones in order and opens each eligible zone's valve for a programmed number of 1 Hz ticks, with a settle gap between zones. Zones that are disabled, over quota or have zero duration are skipped. It replaces the level-only auto-cycle select: its `zone` output drives the irrigation core's user select, and `valve_req` gates the valve.

## Interface
- NUM_ZONES, 4, number of zones/users
- ZONE_W, 2, zone index width ($clog2(NUM_ZONES))
- DUR_W, 8, duration/remaining counter width (ticks)
- SETTLE_TICKS, 2, ticks of closed valve between zones (0 = no gap)
- DEFAULT_DUR, 10, per-zone duration loaded at reset
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- tick  in  1  one-clk pulse per second, synchronous to clk
- start  in  1  pulse: begin cycle (ignored unless IDLE)
- abort  in  1  pulse/level: terminate cycle
- rain  in  1  level: suspend watering
- zone_enable  in  NUM_ZONES  per-zone participation mask
- quota_exceeded  in  NUM_ZONES  per-zone quota flags from irrigation core
- dur_wr  in  1  write strobe for duration table
- dur_zone  in  ZONE_W  zone index for write
- dur_val  in  DUR_W  duration in ticks
- zone  out  ZONE_W  current zone index
- valve_req  out  1  valve open request (high only in RUN)
- busy  out  1  state != IDLE
- paused  out  1  high in PAUSE
- done  out  1  one-cycle pulse at normal cycle completion
- remaining  out  DUR_W  ticks left for current zone

## Operation
- States: IDLE, SELECT, RUN, PAUSE, SETTLE, DONE. All outputs registered/Moore.
- IDLE: zone=0. On start go to SELECT with idx=0.
- SELECT: evaluates one zone per clk. If enable[idx] & !quota_exceeded[idx] & dur[idx]!=0, load remaining=dur[idx] and go to RUN. Otherwise, if idx==NUM_ZONES-1 go to DONE, else idx+1 and stay in SELECT.
- RUN: valve_req=1. Each tick decrements remaining. A tick at remaining==1 sets remaining=0 and goes to SETTLE. quota_exceeded[idx] asserting ends the zone early and goes to SETTLE.
- PAUSE: entered from RUN when rain=1. valve_req=0, remaining frozen, ticks ignored. Returns to RUN when rain=0. quota/tick evaluation resumes from the following clk.
- SETTLE: gap counter loaded with SETTLE_TICKS and decremented on tick. At 0: if idx==NUM_ZONES-1 go to DONE, else idx+1 and go to SELECT. With SETTLE_TICKS=0, SETTLE lasts exactly one clk.
- DONE: done=1 for one clk, then IDLE.
- Priority within a clk: abort > rain > quota_exceeded > tick. abort in any state goes to IDLE next edge and does not produce done.
- Duration table: writable in any state. A write only affects later loads; the remaining count of the running zone is unchanged. dur_wr and a SELECT load of the same zone in the same clk load the old value.
- start while busy is ignored; start coincident with abort is ignored.
- remaining width: DUR_W, no wrap (decrements never go below 0).

## Timing
- Reset (async): state=IDLE, zone=0, valve_req=0, busy=0, paused=0, done=0, remaining=0, all durations=DEFAULT_DUR, gap counter=0.
- Reset deassertion mid-cycle: no resume; the block restarts in IDLE.
- start at edge k: busy=1 after k. If zone 0 is eligible, valve_req=1 after k+1 (2-clk latency).
- Skipping: one clk per ineligible zone.
- Zone with duration D runs D ticks. valve_req falls on the clk edge that samples the D-th tick.
- rain: paused/valve_req change on the edge after rain is sampled (1 clk).
- abort: valve_req=0 and busy=0 on the next edge.
- All-ineligible cycle: done pulses NUM_ZONES+1 clks after start, and valve_req never rises.

## Structure
- Shared package irrigation_pkg holds: seq_state_t enum (IDLE, SELECT, RUN, PAUSE, SETTLE, DONE), NUM_ZONES, ZONE_W, DUR_W defaults. The irrigation top also uses these.
- One sub-module: zone_dur_regs (NUM_ZONES x DUR_W duration register file; async reset to DEFAULT_DUR; single write port; combinational read by index).
- The FSM, tick counters and index register live in zone_sequencer.

## Test plan
- Durations {3,2,0,1}, all enabled, SETTLE_TICKS=2 → zones 0,1,3 open for exactly 3, 2 and 1 ticks, zone 2 is skipped, there are 2-tick gaps between zones, and done pulses once.
- quota_exceeded=4'b0010 before start, durations all 2 → zone 1 is never selected and valve_req is low throughout zone 1's slot.
- Zone 0 with D=5: raise rain after 2 ticks, hold it for 4 ticks, then drop it → paused=1, valve_req=0, remaining holds 3. Zone 0 then finishes after 3 more ticks (5 RUN ticks in total).
- abort in RUN of zone 2 → next edge gives valve_req=0, busy=0, zone=0, and done never pulses. A following start restarts from zone 0.
- dur_wr zone 0 = 9 during zone 0 RUN (D=4) → the current run lasts 4 ticks. A second cycle runs zone 0 for 9 ticks. Also check a start pulse during busy is ignored.
- zone_enable=0 → done pulses 5 clks after start, and busy falls after it.
